fmul_pipe: RTL
==============

FMUL_PIPE -- requirements
Module: fmul_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
REQ-003 Parameter TAG_W, default 5, width of the sideband tag carried alongside each operation.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 in_valid  input  1  operand pair presented.
REQ-007 in_ready  output  1  pipeline accepts operands this cycle.
REQ-008 x1, x2  input  W each  operands: {sign, biased exponent, fraction}.
REQ-009 in_tag  input  TAG_W  sideband tag, returned unmodified with the result.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 y  output  W  product.
REQ-013 out_tag  output  TAG_W  tag of the operation in y.
REQ-014 flags  output  3  {ovf, udf, inv}, valid with out_valid.

Function
REQ-015 Three pipeline stages: S1 unpack and partial products; S2 product sum, exponent sum; S3 normalise, round, and pack into output registers.
REQ-016 Latency is exactly 3 cycles: an operand accepted at edge N gives out_valid=1 after edge N+3 when no stall occurs.
REQ-017 Transfer in: in_valid & in_ready at a rising edge; transfer out: out_valid & out_ready at a rising edge.
REQ-018 in_ready = !out_valid | out_ready (global stall); it is combinational from out_ready.
REQ-019 Stall: while out_valid=1 and out_ready=0, all stages hold their contents, and y/out_tag/flags stay stable.
REQ-020 Throughput: one result per cycle when out_ready is held at 1.
REQ-021 Each stage carries its own valid bit; bubbles propagate as valid=0, and bubbles are not compressed during a stall.
REQ-022 Sign: sign(y) = sign(x1) XOR sign(x2), for all cases including zero and inf.
REQ-023 Zero: an operand with exponent=0 is treated as zero (no denormals); the result is signed zero with flags 000, unless the other operand is inf.
REQ-024 Inf: an operand with exponent all-ones is treated as inf (fraction ignored, no NaN output); the result is signed inf with flags 000.
REQ-025 Invalid: 0 × inf gives signed zero with inv=1.
REQ-026 Normal mantissa product: (1.f1)·(1.f2) is computed at full 2·(MAN_W+1) precision, with no truncated partial products.
REQ-027 Exponent: e = e1 + e2 − BIAS, with BIAS = 2^(EXP_W−1) − 1, computed signed at EXP_W+2 bits; add 1 when the product ≥ 2.0.
REQ-028 Rounding: round-to-nearest, ties-to-even, on the full product; a mantissa carry-out from rounding increments e.
REQ-029 Underflow: final e ≤ 0 gives signed zero with udf=1 (flush, no denormal output).
REQ-030 Overflow: final e ≥ 2^EXP_W − 1 gives signed inf (exponent all-ones, fraction 0) with ovf=1.
REQ-031 Boundary: e1 + e2 exactly at BIAS+1 is normal (e=1); the carry from rounding 1.11…1 into 2.0 is handled before the overflow and underflow checks.
REQ-032 The tag travels with its operation through every stage and stall.

Reset
REQ-033 rstn=0 immediately clears all stage valid bits; out_valid=0, y=0, out_tag=0, flags=0.
REQ-034 Operations in flight at reset are discarded and never emerge.
REQ-035 in_ready=1 while in reset, but no transfer is recorded until the first edge after rstn rises.
REQ-036 The datapath registers other than the output and valid registers need no reset.

Verification
REQ-037 Basic: x1=0x3FC00000, x2=0x40000000, tag=3, out_ready=1 -> 3 cycles later y=0x40400000, out_tag=3, flags=000.
REQ-038 Rounding tie/even: 0x3F800001 × 0x3F800001 -> y=0x3F800002; 0xBFFFFFFF × 0x3FFFFFFF -> y=0xC07FFFFE.
REQ-039 Exceptions:
- 0x7F000000 × 0x7F000000 -> 0x7F800000, ovf=1.
- 0x00800000 × 0x00800000 -> 0x00000000, udf=1.
- 0x80000000 × 0x7F800000 -> 0x80000000, inv=1.
REQ-040 Stall: issue 4 ops back-to-back, hold out_ready=0 for 6 cycles after the first out_valid -> y is stable, in_ready=0, and all 4 results emerge in order with correct tags after release, none lost or duplicated.
REQ-041 Reset mid-operation: assert rstn=0 with 3 ops in flight, release, issue 1 op -> only that op's result appears, at latency 3.
REQ-042 Random regression: 10^5 random normal operands at random in_valid/out_ready duty -> bit-exact match against a reference model applying REQ-022 to REQ-031, with tag order preserved.

Source files
------------

// File: rtl/fmul_pipe.sv
// fmul_pipe: pipelined floating-point multiplier for {sign, biased exponent, fraction} words.
// Operands are registered on acceptance and then pass through three compute stages:
//   S1 unpack/classify + partial products, S2 product sum + exponent sum,
//   S3 normalise/round/pack into the output registers.
// A single global advance (in_ready) moves every stage together, so a stalled output
// freezes the whole pipe and bubbles keep their positions.
module fmul_pipe #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  parameter  int TAG_W = 5,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x1,
  input  logic [W-1:0]     x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     y,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       flags
);

  localparam int M    = MAN_W + 1;
  localparam int PW   = 2 * M;
  localparam int EW   = EXP_W + 2;
  localparam int LO_W = M / 2;
  localparam int HI_W = M - LO_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_OVF  = EW'(EMAX);

  logic w_adv;

  // operand register
  logic             r_s0_valid;
  logic [W-1:0]     r_s0_x1;
  logic [W-1:0]     r_s0_x2;
  logic [TAG_W-1:0] r_s0_tag;

  // S1 results
  logic               r_s1_valid;
  logic               r_s1_sign;
  logic [EXP_W-1:0]   r_s1_e1;
  logic [EXP_W-1:0]   r_s1_e2;
  logic               r_s1_zero;
  logic               r_s1_inf;
  logic [M+LO_W-1:0]  r_s1_pp_lo;
  logic [M+HI_W-1:0]  r_s1_pp_hi;
  logic [TAG_W-1:0]   r_s1_tag;

  // S2 results
  logic                 r_s2_valid;
  logic                 r_s2_sign;
  logic                 r_s2_zero;
  logic                 r_s2_inf;
  logic [PW-1:0]        r_s2_prod;
  logic signed [EW-1:0] r_s2_esum;
  logic [TAG_W-1:0]     r_s2_tag;

  // output registers
  logic             r_out_valid;
  logic [W-1:0]     r_y;
  logic [TAG_W-1:0] r_out_tag;
  logic [2:0]       r_flags;

  assign in_ready  = ~r_out_valid | out_ready;
  assign w_adv     = in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign out_tag   = r_out_tag;
  assign flags     = r_flags;

  // ---------------- S1: unpack, classify, partial products ----------------
  logic [EXP_W-1:0]  w_s1_e1;
  logic [EXP_W-1:0]  w_s1_e2;
  logic [M-1:0]      w_s1_m1;
  logic [M-1:0]      w_s1_m2;
  logic [M+LO_W-1:0] w_s1_pp_lo;
  logic [M+HI_W-1:0] w_s1_pp_hi;

  assign w_s1_e1 = r_s0_x1[W-2 -: EXP_W];
  assign w_s1_e2 = r_s0_x2[W-2 -: EXP_W];
  assign w_s1_m1 = {1'b1, r_s0_x1[MAN_W-1:0]};
  assign w_s1_m2 = {1'b1, r_s0_x2[MAN_W-1:0]};

  // m2 is split in two halves; both products are exact, nothing is truncated
  assign w_s1_pp_lo = {{LO_W{1'b0}}, w_s1_m1} * {{M{1'b0}}, w_s1_m2[LO_W-1:0]};
  assign w_s1_pp_hi = {{HI_W{1'b0}}, w_s1_m1} * {{M{1'b0}}, w_s1_m2[M-1:LO_W]};

  // ---------------- S2: product sum, exponent sum ----------------
  logic [PW-1:0]        w_s2_prod;
  logic signed [EW-1:0] w_s2_esum;

  assign w_s2_prod = {r_s1_pp_hi, {LO_W{1'b0}}} + {{HI_W{1'b0}}, r_s1_pp_lo};
  assign w_s2_esum = EW'(r_s1_e1) + EW'(r_s1_e2) - EW'(BIAS);

  // ---------------- S3: normalise, round, pack ----------------
  logic                 w_s3_hi;
  logic [PW-2:0]        w_s3_norm;
  logic [MAN_W-1:0]     w_s3_frac;
  logic                 w_s3_guard;
  logic                 w_s3_sticky;
  logic                 w_s3_rnd;
  logic [MAN_W:0]       w_s3_frac_r;
  logic signed [EW-1:0] w_s3_e;
  logic                 w_s3_udf;
  logic                 w_s3_ovf;
  logic [W-1:0]         w_s3_y;
  logic [2:0]           w_s3_flags;

  // product is in [1,4); after the optional shift the leading one sits just above bit PW-2
  assign w_s3_hi     = r_s2_prod[PW-1];
  assign w_s3_norm   = w_s3_hi ? r_s2_prod[PW-2:0] : {r_s2_prod[PW-3:0], 1'b0};
  assign w_s3_frac   = w_s3_norm[PW-2:M];
  assign w_s3_guard  = w_s3_norm[M-1];
  assign w_s3_sticky = |w_s3_norm[M-2:0];
  assign w_s3_rnd    = w_s3_guard & (w_s3_sticky | w_s3_frac[0]);
  assign w_s3_frac_r = {1'b0, w_s3_frac} + {{MAN_W{1'b0}}, w_s3_rnd};

  // rounding carry (1.11..1 -> 2.0) leaves fraction zero and bumps the exponent
  // before the range checks below
  assign w_s3_e   = r_s2_esum + EW'(w_s3_hi) + EW'(w_s3_frac_r[MAN_W]);
  assign w_s3_udf = (w_s3_e <= E_ZERO);
  assign w_s3_ovf = (w_s3_e >= E_OVF);

  // result selection: 0*inf, inf, zero, underflow, overflow, then normal
  always_comb begin
    w_s3_y        = '0;
    w_s3_flags    = 3'b000;
    w_s3_y[W-1]   = r_s2_sign;
    if (r_s2_zero && r_s2_inf) begin
      w_s3_flags = 3'b001;
    end else if (r_s2_inf) begin
      w_s3_y[W-2 -: EXP_W] = '1;
    end else if (!r_s2_zero) begin
      if (w_s3_udf) begin
        w_s3_flags = 3'b010;
      end else if (w_s3_ovf) begin
        w_s3_y[W-2 -: EXP_W] = '1;
        w_s3_flags           = 3'b100;
      end else begin
        w_s3_y[W-2 -: EXP_W] = w_s3_e[EXP_W-1:0];
        w_s3_y[MAN_W-1:0]    = w_s3_frac_r[MAN_W-1:0];
      end
    end
  end

  // stage valid bits; reset discards everything in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (w_adv) begin
      r_s0_valid <= in_valid;
      r_s1_valid <= r_s0_valid;
      r_s2_valid <= r_s1_valid;
    end
  end

  // datapath registers, held together with the valids on a stall
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s0_x1    <= x1;
      r_s0_x2    <= x2;
      r_s0_tag   <= in_tag;

      r_s1_sign  <= r_s0_x1[W-1] ^ r_s0_x2[W-1];
      r_s1_e1    <= w_s1_e1;
      r_s1_e2    <= w_s1_e2;
      r_s1_zero  <= ~|w_s1_e1 | ~|w_s1_e2;
      r_s1_inf   <= &w_s1_e1 | &w_s1_e2;
      r_s1_pp_lo <= w_s1_pp_lo;
      r_s1_pp_hi <= w_s1_pp_hi;
      r_s1_tag   <= r_s0_tag;

      r_s2_sign  <= r_s1_sign;
      r_s2_zero  <= r_s1_zero;
      r_s2_inf   <= r_s1_inf;
      r_s2_prod  <= w_s2_prod;
      r_s2_esum  <= w_s2_esum;
      r_s2_tag   <= r_s1_tag;
    end
  end

  // output registers, cleared on reset so y/out_tag/flags read zero while idle after reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_out_tag   <= '0;
      r_flags     <= 3'b000;
    end else if (w_adv) begin
      r_out_valid <= r_s2_valid;
      r_y         <= w_s3_y;
      r_out_tag   <= r_s2_tag;
      r_flags     <= w_s3_flags;
    end
  end

endmodule
